// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand-fetch stage: default widths, ALU opcodes
// and the immediate-extension helper.
package alu_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int IMM_W  = 16;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b100;
  localparam logic [2:0] ALU_XOR = 3'b101;

  function automatic logic [DATA_W-1:0] ext_imm(input logic [IMM_W-1:0] imm, input logic sext);
    logic [DATA_W-1:0] res;
    if (sext) begin
      res = {{(DATA_W-IMM_W){imm[IMM_W-1]}}, imm};
    end else begin
      res = {{(DATA_W-IMM_W){1'b0}}, imm};
    end
    return res;
  endfunction

endpackage

// File: rtl/alu_operand_stage_reg_file.sv
// Register file: two asynchronous read ports with same-cycle write-back
// forwarding and one synchronous write port; R[0] is hard-wired to zero.
module reg_file #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd
);

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];

  // Next-state of the register array; writes to R[0] are discarded.
  always_comb begin
    regs_d = regs_q;
    if (we && (wa != {ADDR_W{1'b0}})) begin
      regs_d[wa] = wd;
    end else begin
      regs_d = regs_q;
    end
  end

  // Register array storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= {DATA_W{1'b0}};
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Read ports with write-back bypass so a consumer sees ALU_DC in the same cycle.
  always_comb begin
    rd1 = {DATA_W{1'b0}};
    rd2 = {DATA_W{1'b0}};
    if (ra1 == {ADDR_W{1'b0}}) begin
      rd1 = {DATA_W{1'b0}};
    end else if (we && (wa == ra1)) begin
      rd1 = wd;
    end else begin
      rd1 = regs_q[ra1];
    end
    if (ra2 == {ADDR_W{1'b0}}) begin
      rd2 = {DATA_W{1'b0}};
    end else if (we && (wa == ra2)) begin
      rd2 = wd;
    end else begin
      rd2 = regs_q[ra2];
    end
  end

endmodule

// File: rtl/alu_operand_stage.sv
// Operand-fetch stage ahead of the ALU: register read, immediate select, busy
// scoreboard for pending write-backs and a single output pipeline register.
module alu_operand_stage #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_rs,
  input  logic [ADDR_W-1:0] in_rt,
  input  logic [ADDR_W-1:0] in_rd,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              in_use_imm,
  input  logic              in_sext,
  input  logic [2:0]        in_aluop,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] ALU_DA,
  output logic [DATA_W-1:0] ALU_DB,
  output logic [2:0]        ALUOp,
  output logic [ADDR_W-1:0] out_wa,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data
);

  import alu_pkg::*;

  localparam int NREGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] rs_val_s, rt_val_s;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic              hazard_s, accept_s;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] alu_da_q, alu_da_d, alu_db_q, alu_db_d;
  logic [2:0]        aluop_q, aluop_d;
  logic [ADDR_W-1:0] out_wa_q, out_wa_d;

  reg_file #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_reg_file (
    .clk   (clk),
    .rst_n (rst_n),
    .ra1   (in_rs),
    .ra2   (in_rt),
    .rd1   (rs_val_s),
    .rd2   (rt_val_s),
    .we    (wb_en),
    .wa    (wb_addr),
    .wd    (wb_data)
  );

  // A source stalls only if busy and not being retired by this cycle's write-back.
  always_comb begin
    hazard_s = (busy_q[in_rs] && !(wb_en && (wb_addr == in_rs))) ||
               (!in_use_imm && busy_q[in_rt] && !(wb_en && (wb_addr == in_rt)));
    in_ready = !hazard_s && (!out_valid_q || out_ready);
    accept_s = in_valid && in_ready;
  end

  // Scoreboard update: a new producer's set overrides a same-address clear.
  always_comb begin
    busy_d = busy_q;
    if (wb_en) begin
      busy_d[wb_addr] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (accept_s && (in_rd != {ADDR_W{1'b0}})) begin
      busy_d[in_rd] = 1'b1;
    end else begin
      busy_d[0] = 1'b0;
    end
    busy_d[0] = 1'b0;
  end

  // Output register next-state: load on accept, drop valid when taken, else hold.
  always_comb begin
    out_valid_d = out_valid_q;
    alu_da_d    = alu_da_q;
    alu_db_d    = alu_db_q;
    aluop_d     = aluop_q;
    out_wa_d    = out_wa_q;
    if (accept_s) begin
      out_valid_d = 1'b1;
      alu_da_d    = rs_val_s;
      alu_db_d    = in_use_imm ? ext_imm(in_imm, in_sext) : rt_val_s;
      aluop_d     = in_aluop;
      out_wa_d    = in_rd;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= {NREGS{1'b0}};
      out_valid_q <= 1'b0;
      alu_da_q    <= {DATA_W{1'b0}};
      alu_db_q    <= {DATA_W{1'b0}};
      aluop_q     <= ALU_ADD;
      out_wa_q    <= {ADDR_W{1'b0}};
    end else begin
      busy_q      <= busy_d;
      out_valid_q <= out_valid_d;
      alu_da_q    <= alu_da_d;
      alu_db_q    <= alu_db_d;
      aluop_q     <= aluop_d;
      out_wa_q    <= out_wa_d;
    end
  end

  assign out_valid = out_valid_q;
  assign ALU_DA    = alu_da_q;
  assign ALU_DB    = alu_db_q;
  assign ALUOp     = aluop_q;
  assign out_wa    = out_wa_q;

endmodule

// File: tb/tb_alu_operand_stage.sv
// Directed bench for alu_operand_stage: reset, register/immediate operands,
// hazard stall with forwarding, backpressure, R0 handling and scoreboard set priority.
module tb_alu_operand_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_use_imm, in_sext, out_valid, out_ready, wb_en;
  logic [4:0]  in_rs, in_rt, in_rd, out_wa, wb_addr;
  logic [15:0] in_imm;
  logic [2:0]  in_aluop, ALUOp;
  logic [31:0] ALU_DA, ALU_DB, wb_data;

  int errors = 0;
  int checks = 0;

  alu_operand_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_imm(in_imm),
    .in_use_imm(in_use_imm), .in_sext(in_sext), .in_aluop(in_aluop),
    .out_valid(out_valid), .out_ready(out_ready), .ALU_DA(ALU_DA), .ALU_DB(ALU_DB),
    .ALUOp(ALUOp), .out_wa(out_wa), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                       input logic [15:0] imm, input logic use_imm, input logic sext,
                       input logic [2:0] op);
    in_valid = 1'b1; in_rs = rs; in_rt = rt; in_rd = rd;
    in_imm = imm; in_use_imm = use_imm; in_sext = sext; in_aluop = op;
  endtask

  task automatic wb(input logic en, input logic [4:0] a, input logic [31:0] d);
    wb_en = en; wb_addr = a; wb_data = d;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    issue(5'd0, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 3'b000);
    in_valid = 1'b0;
    wb(1'b0, 5'd0, 32'h0);
    #12;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_da", ALU_DA, 32'h0);
    chk("rst_db", ALU_DB, 32'h0);
    chk("rst_aluop", {29'd0, ALUOp}, 32'd0);
    rst_n = 1'b1;

    // register operands
    tick();
    wb(1'b1, 5'd5, 32'h96ACB255);
    tick();
    wb(1'b1, 5'd6, 32'h368BDD69);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    issue(5'd5, 5'd6, 5'd7, 16'h0000, 1'b0, 1'b0, 3'b001);
    #1 chk("reg_in_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("reg_valid", {31'd0, out_valid}, 32'd1);
    chk("reg_da", ALU_DA, 32'h96ACB255);
    chk("reg_db", ALU_DB, 32'h368BDD69);
    chk("reg_aluop", {29'd0, ALUOp}, 32'd1);
    chk("reg_wa", {27'd0, out_wa}, 32'd7);

    // immediates
    issue(5'd0, 5'd0, 5'd0, 16'h8001, 1'b1, 1'b1, 3'b000);
    tick();
    chk("sext_db", ALU_DB, 32'hFFFF8001);
    chk("sext_da", ALU_DA, 32'h0);
    in_sext = 1'b0;
    tick();
    chk("zext_db", ALU_DB, 32'h00008001);
    chk("zext_da", ALU_DA, 32'h0);

    // hazard on r7, released by same-cycle write-back
    issue(5'd7, 5'd0, 5'd0, 16'h0000, 1'b1, 1'b0, 3'b010);
    #1 chk("haz_ready0", {31'd0, in_ready}, 32'd0);
    tick();
    chk("haz_valid_drop", {31'd0, out_valid}, 32'd0);
    chk("haz_ready1", {31'd0, in_ready}, 32'd0);
    wb(1'b1, 5'd7, 32'h00001234);
    #1 chk("haz_ready_wb", {31'd0, in_ready}, 32'd1);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    chk("haz_da", ALU_DA, 32'h00001234);
    chk("haz_aluop", {29'd0, ALUOp}, 32'd2);
    chk("haz_valid", {31'd0, out_valid}, 32'd1);

    // backpressure
    issue(5'd5, 5'd6, 5'd3, 16'h0000, 1'b0, 1'b0, 3'b101);
    tick();
    chk("bp_da0", ALU_DA, 32'h96ACB255);
    out_ready = 1'b0;
    issue(5'd6, 5'd5, 5'd4, 16'h0000, 1'b0, 1'b0, 3'b100);
    for (int i = 0; i < 3; i++) begin
      #1 chk("bp_ready", {31'd0, in_ready}, 32'd0);
      tick();
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_da", ALU_DA, 32'h96ACB255);
      chk("bp_db", ALU_DB, 32'h368BDD69);
      chk("bp_aluop", {29'd0, ALUOp}, 32'd5);
      chk("bp_wa", {27'd0, out_wa}, 32'd3);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("bp_next_da", ALU_DA, 32'h368BDD69);
    chk("bp_next_db", ALU_DB, 32'h96ACB255);
    chk("bp_next_aluop", {29'd0, ALUOp}, 32'd4);
    chk("bp_next_wa", {27'd0, out_wa}, 32'd4);

    // R0 writes ignored, rd=0 never busies r0
    in_valid = 1'b0;
    wb(1'b1, 5'd0, 32'hFFFFFFFF);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    issue(5'd0, 5'd0, 5'd0, 16'h0000, 1'b0, 1'b0, 3'b011);
    tick();
    chk("r0_da", ALU_DA, 32'h0);
    chk("r0_db", ALU_DB, 32'h0);
    chk("r0_aluop", {29'd0, ALUOp}, 32'd3);
    chk("r0_wa", {27'd0, out_wa}, 32'd0);
    issue(5'd0, 5'd0, 5'd5, 16'h0000, 1'b0, 1'b0, 3'b000);
    wb(1'b1, 5'd0, 32'hFFFFFFFF);
    #1 chk("r0_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("r0_fwd_da", ALU_DA, 32'h0);

    // set wins over same-cycle clear of the same register
    issue(5'd0, 5'd0, 5'd9, 16'h0000, 1'b1, 1'b0, 3'b000);
    wb(1'b1, 5'd9, 32'h00000055);
    tick();
    wb(1'b0, 5'd0, 32'h0);
    issue(5'd9, 5'd0, 5'd0, 16'h0000, 1'b1, 1'b0, 3'b000);
    #1 chk("setwins_ready", {31'd0, in_ready}, 32'd0);

    // reset mid-cycle
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_da", ALU_DA, 32'h0);
    chk("midrst_db", ALU_DB, 32'h0);
    chk("midrst_aluop", {29'd0, ALUOp}, 32'd0);
    chk("midrst_wa", {27'd0, out_wa}, 32'd0);
    #3 rst_n = 1'b1;
    tick();
    issue(5'd5, 5'd5, 5'd0, 16'h0000, 1'b0, 1'b0, 3'b000);
    #1 chk("postrst_ready", {31'd0, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0;
    chk("postrst_valid", {31'd0, out_valid}, 32'd1);
    chk("postrst_r5", ALU_DA, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
